// File: rtl/debounce_l2p_multi.sv
// Multi-channel debouncer: per-channel 2-flop synchronizer, stability counter,
// debounced level and one-cycle accepted-edge pulses with a lowest-index event summary.
module debounce_l2p_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int EDGE_MODE     = 0,
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1,
    localparam int EW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] signal_in,
    output logic [N_CH-1:0] signal_out,
    output logic [N_CH-1:0] level_out,
    output logic            evt_valid,
    output logic [EW-1:0]   evt_ch,
    output logic            evt_rise
);

    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam bit RISE_EN = (EDGE_MODE != 1);
    localparam bit FALL_EN = (EDGE_MODE != 0);

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] pulse_q;
    logic [CW-1:0]   cnt [N_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
        end
    end

    // A channel accepts a new level only after STABLE_CYCLES consecutive
    // synchronized samples disagree with the current level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pulse_q[i] <= 1'b0;
                if (sync2[i] == level_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level_q[i] <= sync2[i];
                    cnt[i]     <= '0;
                    pulse_q[i] <= sync2[i] ? RISE_EN : FALL_EN;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign signal_out = pulse_q;
    assign level_out  = level_q;
    assign evt_valid  = |pulse_q;

    // Scan downward so the lowest pulsing channel wins; the level it just
    // took tells whether the edge was rising.
    always_comb begin
        evt_ch   = '0;
        evt_rise = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pulse_q[i]) begin
                evt_ch   = EW'(i);
                evt_rise = level_q[i];
            end
        end
    end

endmodule

// File: tb/tb_debounce_l2p_multi.sv
// Directed bench: both-edge, rising-only and single-cycle-stability debouncers
// sharing one stimulus, checked with immediate assertions after each step.
module tb_debounce_l2p_multi;

    logic       clk;
    logic       rst;
    logic [3:0] sig;

    logic [3:0] a_out, a_lvl, b_out, b_lvl;
    logic       a_vld, a_rise, b_vld, b_rise;
    logic [1:0] a_ch, b_ch;
    logic [0:0] c_out, c_lvl, c_ch;
    logic       c_vld, c_rise;

    int total = 0;
    int bad   = 0;

    debounce_l2p_multi #(.N_CH(4), .STABLE_CYCLES(4), .EDGE_MODE(2)) dut_a (
        .clk(clk), .rst(rst), .signal_in(sig), .signal_out(a_out), .level_out(a_lvl),
        .evt_valid(a_vld), .evt_ch(a_ch), .evt_rise(a_rise)
    );

    debounce_l2p_multi #(.N_CH(4), .STABLE_CYCLES(4), .EDGE_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .signal_in(sig), .signal_out(b_out), .level_out(b_lvl),
        .evt_valid(b_vld), .evt_ch(b_ch), .evt_rise(b_rise)
    );

    debounce_l2p_multi #(.N_CH(1), .STABLE_CYCLES(1), .EDGE_MODE(2)) dut_c (
        .clk(clk), .rst(rst), .signal_in(sig[0:0]), .signal_out(c_out), .level_out(c_lvl),
        .evt_valid(c_vld), .evt_ch(c_ch), .evt_rise(c_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int bounce [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        rst = 1'b1;
        sig = 4'b0000;
        step(2);
        check("rst_lvl", 32'(a_lvl), 0);
        check("rst_out", 32'(a_out), 0);
        check("rst_vld", 32'(a_vld), 0);
        check("rst_ch", 32'(a_ch), 0);
        check("rst_rise", 32'(a_rise), 0);
        rst = 1'b0;
        step(2);

        // ch0 rises and is held; single-cycle instance accepts at edge 3
        sig[0] = 1'b1;
        step(3);
        check("c_rise_lvl", 32'(c_lvl), 1);
        check("c_rise_out", 32'(c_out), 1);
        step(2);
        check("ch0_e5_lvl", 32'(a_lvl), 0);
        check("ch0_e5_out", 32'(a_out), 0);
        step(1);
        check("ch0_e6_lvl", 32'(a_lvl), 4'b0001);
        check("ch0_e6_out", 32'(a_out), 4'b0001);
        check("ch0_e6_vld", 32'(a_vld), 1);
        check("ch0_e6_ch", 32'(a_ch), 0);
        check("ch0_e6_rise", 32'(a_rise), 1);
        check("ch0_e6_b_out", 32'(b_out), 4'b0001);
        step(1);
        check("ch0_e7_out", 32'(a_out), 0);
        check("ch0_e7_lvl", 32'(a_lvl), 4'b0001);

        // ch1 bounces then settles high: one pulse, at the 6th edge of the final high
        for (int k = 0; k < 10; k++) begin
            sig[1] = bounce[k][0];
            step(1);
            check("ch1_bounce_out", 32'(a_out), 0);
        end
        step(1);
        check("ch1_acc_out", 32'(a_out), 4'b0010);
        check("ch1_acc_lvl", 32'(a_lvl), 4'b0011);
        check("ch1_acc_ch", 32'(a_ch), 1);
        check("ch1_acc_rise", 32'(a_rise), 1);
        step(1);
        check("ch1_after_out", 32'(a_out), 0);

        // ch2 and ch3 rise together
        sig[3:2] = 2'b11;
        step(5);
        check("ch23_e5_out", 32'(a_out), 0);
        step(1);
        check("ch23_out", 32'(a_out), 4'b1100);
        check("ch23_lvl", 32'(a_lvl), 4'b1111);
        check("ch23_vld", 32'(a_vld), 1);
        check("ch23_ch", 32'(a_ch), 2);
        check("ch23_rise", 32'(a_rise), 1);
        check("ch23_b_out", 32'(b_out), 4'b1100);
        step(1);
        check("ch23_after", 32'(a_out), 0);

        // ch0 falls: both-edge instance pulses, rising-only instance stays quiet
        sig[0] = 1'b0;
        step(3);
        check("c_fall_lvl", 32'(c_lvl), 0);
        check("c_fall_out", 32'(c_out), 1);
        step(2);
        check("fall_e5_lvl", 32'(a_lvl), 4'b1111);
        step(1);
        check("fall_a_lvl", 32'(a_lvl), 4'b1110);
        check("fall_a_out", 32'(a_out), 4'b0001);
        check("fall_a_vld", 32'(a_vld), 1);
        check("fall_a_rise", 32'(a_rise), 0);
        check("fall_b_lvl", 32'(b_lvl), 4'b1110);
        check("fall_b_out", 32'(b_out), 0);
        check("fall_b_vld", 32'(b_vld), 0);

        // ch1 to low, then a 3-edge high excursion must be ignored
        sig[1] = 1'b0;
        step(7);
        check("ch1_low_lvl", 32'(a_lvl), 4'b1100);
        sig[1] = 1'b1;
        step(3);
        sig[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("glitch_out", 32'(a_out), 0);
            check("glitch_lvl", 32'(a_lvl), 4'b1100);
        end
        // full count needed again, so the partial count was discarded
        sig[1] = 1'b1;
        step(5);
        check("reglitch_e5_lvl", 32'(a_lvl), 4'b1100);
        step(1);
        check("reglitch_e6_lvl", 32'(a_lvl), 4'b1110);
        check("reglitch_e6_out", 32'(a_out), 4'b0010);

        // reset mid-count on ch0: asynchronous clear, no pulse for the lost change
        sig[0] = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        check("arst_lvl", 32'(a_lvl), 0);
        check("arst_out", 32'(a_out), 0);
        check("arst_vld", 32'(a_vld), 0);
        check("arst_ch", 32'(a_ch), 0);
        check("arst_rise", 32'(a_rise), 0);
        step(1);
        rst = 1'b0;
        step(3);
        check("post_c_lvl", 32'(c_lvl), 1);
        check("post_c_out", 32'(c_out), 1);
        step(2);
        check("post_e5_lvl", 32'(a_lvl), 0);
        check("post_e5_out", 32'(a_out), 0);
        step(1);
        check("post_e6_lvl", 32'(a_lvl), 4'b1111);
        check("post_e6_out", 32'(a_out), 4'b1111);
        check("post_e6_ch", 32'(a_ch), 0);
        check("post_e6_rise", 32'(a_rise), 1);
        check("post_e6_b_out", 32'(b_out), 4'b1111);
        step(1);
        check("post_e7_out", 32'(a_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
